// File: rtl/mantissa_sub53_4_pipe.sv
// Two-stage pipelined subtractor Diff = A - zext(B) for significand decrement
// and borrow-back corrections; stage 1 takes the low SPLIT bits, stage 2 the rest.
module mantissa_sub53_4_pipe #(
  parameter int WIDTH_A = 53,
  parameter int WIDTH_B = 4,
  parameter int SPLIT   = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH_A-1:0] A,
  input  logic [WIDTH_B-1:0] B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH_A-1:0] Diff,
  output logic               Borrow,
  output logic               Zero
);

  localparam int HW = WIDTH_A - SPLIT;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // A producer holds valid and data stable until ready; a stage advances when
  // it is empty or the stage after it is consuming, so in_ready is the only
  // combinational path (from out_ready) through the block.

  logic            s1_valid_q, s1_valid_d;
  logic [SPLIT-1:0] s1_low_q, s1_low_d;
  logic            s1_b1_q, s1_b1_d;
  logic [HW-1:0]   s1_high_q, s1_high_d;
  logic            s1_lz_q, s1_lz_d;

  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH_A-1:0] diff_q, diff_d;
  logic               borrow_q, borrow_d;
  logic               zero_q, zero_d;

  logic           s1_adv, s2_adv;
  logic [SPLIT:0] low_full;
  logic [HW:0]    high_full;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid = s2_valid_q;
  assign Diff      = diff_q;
  assign Borrow    = borrow_q;
  assign Zero      = zero_q;

  always_comb begin
    // Extra top bit of each partial difference is the borrow out.
    low_full  = {1'b0, A[SPLIT-1:0]} - {{(SPLIT + 1 - WIDTH_B){1'b0}}, B};
    high_full = {1'b0, s1_high_q} - {{HW{1'b0}}, s1_b1_q};

    s1_valid_d = s1_valid_q;
    s1_low_d   = s1_low_q;
    s1_b1_d    = s1_b1_q;
    s1_high_d  = s1_high_q;
    s1_lz_d    = s1_lz_q;
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    borrow_d   = borrow_q;
    zero_d     = zero_q;

    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_low_d  = low_full[SPLIT-1:0];
        s1_b1_d   = low_full[SPLIT];
        s1_high_d = A[WIDTH_A-1:SPLIT];
        s1_lz_d   = (low_full[SPLIT-1:0] == '0);
      end
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d   = {high_full[HW-1:0], s1_low_q};
        borrow_d = high_full[HW];
        zero_d   = s1_lz_q && (high_full[HW-1:0] == '0) && !high_full[HW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_low_q   <= '0;
      s1_b1_q    <= 1'b0;
      s1_high_q  <= '0;
      s1_lz_q    <= 1'b0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      borrow_q   <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_low_q   <= s1_low_d;
      s1_b1_q    <= s1_b1_d;
      s1_high_q  <= s1_high_d;
      s1_lz_q    <= s1_lz_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      borrow_q   <= borrow_d;
      zero_q     <= zero_d;
    end
  end

endmodule

// File: doc/mantissa_sub53_4_pipe.md
Name: mantissa_sub53_4_pipe

Overview:
- Two-stage pipelined unsigned subtractor. Computes Diff = A - B, where A is a 53-bit significand and B is a 4-bit decrement.
- It is the decrement counterpart of the 53+4 significand adder. The rounding/normalisation path uses it for decrement and borrow-back corrections.
- Valid/ready handshakes on both sides. Full throughput of one result per cycle. Stalls under backpressure without losing data.

Parameters:
- WIDTH_A, 53, significand operand width.
- WIDTH_B, 4, decrement operand width; zero-extended to WIDTH_A.
- SPLIT, 27, number of low bits computed in stage 1; stage 2 computes the remaining WIDTH_A-SPLIT bits.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A/B valid this cycle.
- in_ready  output  1  block can accept A/B this cycle.
- A  input  WIDTH_A  minuend, unsigned.
- B  input  WIDTH_B  subtrahend, unsigned, zero-extended.
- out_valid  output  1  Diff/Borrow/Zero valid.
- out_ready  input  1  consumer accepts the result this cycle.
- Diff  output  WIDTH_A  (A - B) mod 2^WIDTH_A.
- Borrow  output  1  1 iff A < B.
- Zero  output  1  1 iff A == B.

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, Diff=0, Borrow=0, Zero=0. Internal data registers clear to 0. Any in-flight operations are discarded. in_ready=1 from the first cycle after rst_n deasserts.
- Transfers:
  - Input transfer occurs when in_valid && in_ready at a clock edge.
  - Output transfer occurs when out_valid && out_ready.
- Stage 1, on advance:
  - low = A[SPLIT-1:0] - zero_ext(B), computed SPLIT+1 bits wide.
  - Register: low[SPLIT-1:0], b1 = borrow out of low, high_a = A[WIDTH_A-1:SPLIT], lz = (low[SPLIT-1:0]==0).
- Stage 2, on advance:
  - Diff = {high_a - b1, low}.
  - Borrow = borrow out of the high subtraction.
  - Zero = lz && (high_a - b1 == 0) && !Borrow.
- Advance rules:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv. in_ready is combinational from out_ready; no other combinational in-to-out path is allowed.
  - On s2_adv: s2_valid <= s1_valid; output registers load from s1 only when s1_valid.
  - On s1_adv: s1_valid <= in_valid; s1 data loads only when in_valid.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready is held high.
- Throughput: 1 result per cycle with out_ready=1.
- Stall: while out_valid && !out_ready, Diff/Borrow/Zero/out_valid hold stable. Stage 1 may still fill if empty. in_ready drops only when both stages hold valid data.
- Simultaneous events: a result leaving the output and a new input entering in the same cycle is legal, with no bubble.
- Bubbles: in_valid=0 propagates as an invalid slot. Output data registers keep their last value while out_valid=0.
- Wrap-around: A < B gives Diff = 2^53 + A - B and Borrow=1, Zero=0.
- Boundaries:
  - B=0 yields Diff=A, Borrow=0.
  - A=0 with B=0 yields Zero=1.
- Ordering: results emerge strictly in input order; no drops, no duplicates.
- Unknowns: X on A/B when in_valid=0 must not propagate to out_valid.

Test Plan:
- Reset then single op: A=0x10_0000_0000_0005, B=3, out_ready=1 -> 2 cycles later out_valid=1, Diff=0x10_0000_0000_0002, Borrow=0, Zero=0.
- Cross-split borrow: A=0x0000_0000_8000_000 (bit 27 set, low bits 0), B=1 -> Diff=0x7FF_FFFF, Borrow=0. Also A=2^53-1, B=15 -> Diff=2^53-16.
- Underflow/zero:
  - A=5, B=9 -> Diff=0x1F_FFFF_FFFF_FFFC, Borrow=1, Zero=0.
  - A=7, B=7 -> Diff=0, Zero=1, Borrow=0.
  - A=0, B=0 -> Zero=1.
- Backpressure: stream 5 ops back-to-back with out_ready low for cycles 3-6 -> in_ready falls once both stages are full. Outputs are held stable while stalled. All 5 results arrive in order with correct values; no loss or duplication.
- Random stress: 10,000 random A/B with random in_valid/out_ready toggling -> scoreboard matches the reference subtraction for Diff/Borrow/Zero. Sustained 1/cycle throughput when out_ready=1.
- Reset mid-operation: assert rst_n low asynchronously with both stages valid -> out_valid=0 and Diff=0 immediately. The next op after release yields only its own result; no stale outputs.
